lisnoc_vc_credit_scheduler: RTL
===============================

// Module: lisnoc_vc_credit_scheduler
// PURPOSE
//  Credit-based scheduler that shares one router output link among vchannels output FIFOs.
//  Grants one VC per cycle by round-robin, gated by per-VC downstream credits.
//  Optional packet lock makes the link wormhole-exclusive from HEADER to LAST.
//  Sits between the per-VC output FIFOs and the physical link. Replaces ready-based
//  link arbitration where the downstream side returns credits.
// PARAMETERS
//  flit_data_width  32  payload bits per flit
//  flit_type_width  2   type bits, MSBs of flit (00 PAYLOAD, 01 HEADER, 10 LAST, 11 SINGLE)
//  vchannels        2   number of virtual channels (>=1)
//  credits          4   downstream buffer depth per VC; initial credit count (>=1)
//  packet_lock      1   1: hold grant on one VC from HEADER to LAST; 0: flit-level interleave
// PORTS
//  clk              in   1                   clock
//  rst_n            in   1                   asynchronous reset, active low
//  fifo_valid_i     in   vchannels           per-VC flit available
//  fifo_flit_i      in   vchannels*flit_w    per-VC flit, VC v at [(v+1)*flit_w-1 : v*flit_w]
//  fifo_ready_o     out  vchannels           one-hot grant; the flit is popped this cycle
//  credit_return_i  in   vchannels           per-VC credit returned by downstream, 1 per pulse
//  link_valid_o     out  vchannels           registered one-hot VC tag of link_flit_o
//  link_flit_o      out  flit_w              registered flit driven onto the link
//  err_o            out  1                   sticky protocol or credit error
// BEHAVIOUR
//  - Reset: link_valid_o=0, link_flit_o=0, err_o=0, fifo_ready_o=0, all credits=credits,
//    RR pointer=vchannels-1 (VC0 has first priority), state=IDLE.
//    Reset mid-packet discards the lock and restores all credits.
//  - eligible[v] = fifo_valid_i[v] & (credit[v]!=0) & (state==IDLE | v==lock_vc).
//  - Grant is combinational in the same cycle.
//    Search order is ptr+1, ptr+2, ... mod vchannels; the first eligible VC wins.
//    fifo_ready_o is one-hot or zero.
//  - On a grant: link_flit_o and link_valid_o load at the next edge (1-cycle latency).
//    Pointer <= granted VC.
//  - No grant: link_valid_o <= 0 and link_flit_o holds its value.
//  - The link never back-pressures; credits are the only flow control.
//  - Credits: grant only -> -1; return only -> +1; both on the same VC in one cycle -> unchanged.
//    A return that would take the count above `credits` saturates and sets err_o.
//    Counter width is $clog2(credits+1).
//  - FSM (only when packet_lock=1; otherwise it stays in IDLE):
//      IDLE:   granted HEADER -> LOCKED, lock_vc <= v.
//              Granted SINGLE or LAST stays IDLE.
//              Granted PAYLOAD stays IDLE and sets err_o.
//      LOCKED: only lock_vc is eligible, even at zero credits (the link stalls, no bypass).
//              Granted LAST or SINGLE -> IDLE.
//              Granted HEADER stays LOCKED and sets err_o.
//  - When packet_lock=0, type checks are skipped and err_o reports only credit overflow.
//  - The RR pointer advances on every grant, so an exiting lock resumes at lock_vc+1.
//  - vchannels=1: the pointer is 1 bit wide and unused; the block degenerates to credit gating.
//  - err_o clears only on reset.
// STRUCTURE
//  - Shared package lisnoc_sched_pkg holds:
//      flit type constants (FLIT_PAYLOAD, FLIT_HEADER, FLIT_LAST, FLIT_SINGLE);
//      state enum sched_state_e {IDLE, LOCKED};
//      function clog2_min1(n) for pointer and counter widths.
//  - Sub-module lisnoc_rr_arbiter #(n): inputs req[n] and ptr; outputs one-hot gnt and an
//    encoded index. It is combinational and reused by other router arbiters.
//  - The top level holds the credit counters, FSM, pointer, output register and error logic.
// TESTING
//  1 Single VC stream: vchannels=2, credits=4, VC0 valid for 6 cycles, no returns.
//    Expect 4 grants, link_valid_o=2'b01 one cycle after each grant, then stall.
//    One return pulse -> exactly 1 more grant.
//  2 Fairness: packet_lock=0, both VCs always valid, returns every cycle.
//    Expect grants alternating 01,10,01,10; link_flit_o matches the granted VC's flit
//    with 1-cycle lag.
//  3 Packet lock: VC0 sends HEADER,PAYLOAD,PAYLOAD,LAST while VC1 holds SINGLE.
//    Expect VC1 gets no grant until the cycle after VC0's LAST, then VC1 is granted.
//  4 Lock credit stall: lock VC0 with credits exhausted mid-packet, VC1 valid.
//    Expect zero grants; after 1 return on VC0, VC0 is granted.
//  5 Simultaneous grant and return on VC1 at credit=2: credit stays 2.
//    A return at credit=4 -> err_o=1, credit stays 4.
//  6 Reset mid-packet: assert rst_n=0 while LOCKED on VC1 with credit=1.
//    Expect immediate link_valid_o=0 and fifo_ready_o=0.
//    After release: credits=4, IDLE, VC0 granted first.

Source files
------------

// File: rtl/lisnoc_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lisnoc_sched_pkg                                             |
// | Description : Shared definitions for the LiSNoC VC credit scheduler and    |
// |               the round-robin arbiter: flit type codes, scheduler state    |
// |               encoding and a width helper.                                 |
// | Contents    : FLIT_PAYLOAD/HEADER/LAST/SINGLE, sched_state_e, clog2_min1   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lisnoc_sched_pkg;

  // Flit type codes, carried in the MSBs of every flit.
  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  // Link ownership: IDLE lets any VC compete, LOCKED reserves the link for
  // the VC that sent the last HEADER until its LAST/SINGLE goes out.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  // $clog2 that never returns 0, so a single-entry index still gets a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lisnoc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lisnoc_rr_arbiter                                            |
// | Description : Combinational round-robin arbiter. The search starts at the  |
// |               entry after ptr_i and wraps; the first requester wins.       |
// | Ports       : req_i [n]   request vector                                   |
// |               ptr_i [W]   index of the last winner (lowest priority)       |
// |               gnt_o [n]   one-hot grant, zero when nothing requests        |
// |               idx_o [W]   encoded index of the winner (0 when no grant)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lisnoc_rr_arbiter
  import lisnoc_sched_pkg::*;
#(
  parameter int n = 2
) (
  input  logic [n-1:0]             req_i,
  input  logic [clog2_min1(n)-1:0] ptr_i,
  output logic [n-1:0]             gnt_o,
  output logic [clog2_min1(n)-1:0] idx_o
);

  localparam int W = clog2_min1(n);

  always_comb begin
    logic          found;
    logic [W-1:0]  cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    // Offsets 1..n visit every entry once, ending with ptr_i itself.
    for (int i = 1; i <= n; i++) begin
      cand = W'((int'(ptr_i) + i) % n);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lisnoc_vc_credit_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lisnoc_vc_credit_scheduler                                   |
// | Description : Shares one router output link among per-VC output FIFOs.     |
// |               One VC per cycle is granted round-robin, gated by per-VC     |
// |               downstream credits; optional packet lock keeps the link on   |
// |               one VC from HEADER to LAST.                                  |
// | Ports       : clk, rst_n         clock, async active-low reset             |
// |               fifo_valid_i  [V]  per-VC flit available                     |
// |               fifo_flit_i [V*F]  per-VC flit, VC v at slice v              |
// |               fifo_ready_o  [V]  one-hot grant / pop (combinational)       |
// |               credit_return_i[V] per-VC credit return pulse                |
// |               link_valid_o  [V]  registered one-hot VC tag                 |
// |               link_flit_o   [F]  registered link flit                      |
// |               err_o              sticky protocol / credit error            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lisnoc_vc_credit_scheduler
  import lisnoc_sched_pkg::*;
#(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 2,
  parameter int credits         = 4,
  parameter int packet_lock     = 1
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [vchannels-1:0]                                   fifo_valid_i,
  input  logic [vchannels*(flit_data_width+flit_type_width)-1:0] fifo_flit_i,
  output logic [vchannels-1:0]                                   fifo_ready_o,
  input  logic [vchannels-1:0]                                   credit_return_i,
  output logic [vchannels-1:0]                                   link_valid_o,
  output logic [flit_data_width+flit_type_width-1:0]             link_flit_o,
  output logic                                                   err_o
);

  localparam int FLIT_W = flit_data_width + flit_type_width;
  localparam int PTR_W  = clog2_min1(vchannels);
  localparam int CNT_W  = $clog2(credits + 1);

  localparam logic [CNT_W-1:0]           CREDIT_MAX = CNT_W'(credits);
  localparam logic [flit_type_width-1:0] T_PAYLOAD  = flit_type_width'(FLIT_PAYLOAD);
  localparam logic [flit_type_width-1:0] T_HEADER   = flit_type_width'(FLIT_HEADER);
  localparam logic [flit_type_width-1:0] T_LAST     = flit_type_width'(FLIT_LAST);
  localparam logic [flit_type_width-1:0] T_SINGLE   = flit_type_width'(FLIT_SINGLE);

  // State
  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      lock_vc_q;
  sched_state_e          state_q;
  logic [vchannels-1:0]  link_valid_q;
  logic [FLIT_W-1:0]     link_flit_q;
  logic                  err_q;
  logic [CNT_W-1:0]      credit_q [vchannels];
  logic [CNT_W-1:0]      credit_d [vchannels];

  // Arbitration
  logic [vchannels-1:0]        eligible;
  logic [vchannels-1:0]        gnt;
  logic [PTR_W-1:0]            gnt_idx;
  logic                        gnt_any;
  logic [FLIT_W-1:0]           gnt_flit;
  logic [flit_type_width-1:0]  gnt_type;
  logic                        type_err;
  logic                        credit_err;

  // While locked only lock_vc may compete; a locked VC with no credits
  // stalls the link rather than letting another VC slip in mid-packet.
  for (genvar v = 0; v < vchannels; v++) begin : g_elig
    assign eligible[v] = fifo_valid_i[v]
                       & (credit_q[v] != '0)
                       & ((state_q == IDLE) | (lock_vc_q == PTR_W'(v)));
  end

  lisnoc_rr_arbiter #(
    .n(vchannels)
  ) u_arb (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign gnt_any  = |gnt;
  assign gnt_flit = fifo_flit_i[int'(gnt_idx)*FLIT_W +: FLIT_W];
  assign gnt_type = gnt_flit[FLIT_W-1 -: flit_type_width];

  // Pop is suppressed while reset is held so no flit is lost from a FIFO
  // that the output register cannot capture.
  assign fifo_ready_o = gnt & {vchannels{rst_n}};

  // Packet framing violations, only meaningful when locking is enabled.
  always_comb begin
    type_err = 1'b0;
    if ((packet_lock != 0) && gnt_any) begin
      if ((state_q == IDLE) && (gnt_type == T_PAYLOAD)) begin
        type_err = 1'b1;
      end else if ((state_q == LOCKED) && (gnt_type == T_HEADER)) begin
        type_err = 1'b1;
      end
    end
  end

  // Credit bookkeeping: a grant consumes, a return refunds, both cancel.
  // A refund into a full counter is dropped and flagged.
  always_comb begin
    credit_err = 1'b0;
    for (int v = 0; v < vchannels; v++) begin
      credit_d[v] = credit_q[v];
      if (credit_return_i[v] && !gnt[v]) begin
        if (credit_q[v] == CREDIT_MAX) begin
          credit_err = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CNT_W'(1);
        end
      end else if (gnt[v] && !credit_return_i[v]) begin
        credit_d[v] = credit_q[v] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= PTR_W'(vchannels - 1);
      lock_vc_q    <= '0;
      state_q      <= IDLE;
      link_valid_q <= '0;
      link_flit_q  <= '0;
      err_q        <= 1'b0;
      for (int v = 0; v < vchannels; v++) begin
        credit_q[v] <= CREDIT_MAX;
      end
    end else begin
      link_valid_q <= gnt;
      if (gnt_any) begin
        link_flit_q <= gnt_flit;
        ptr_q       <= gnt_idx;
      end
      for (int v = 0; v < vchannels; v++) begin
        credit_q[v] <= credit_d[v];
      end
      err_q <= err_q | type_err | credit_err;

      if ((packet_lock != 0) && gnt_any) begin
        case (state_q)
          IDLE: begin
            if (gnt_type == T_HEADER) begin
              state_q   <= LOCKED;
              lock_vc_q <= gnt_idx;
            end
          end
          LOCKED: begin
            if ((gnt_type == T_LAST) || (gnt_type == T_SINGLE)) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign link_valid_o = link_valid_q;
  assign link_flit_o  = link_flit_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire
